// File: rtl/binary_counter_param.sv
// ---------------------------------------------------------------------------
// binary_counter_param
//
// Parameterised up/down binary counter with an enable prescaler, optional
// saturation at the range ends, a one-cycle terminal-count pulse and a sticky
// range-end (overflow/underflow) flag.
//
// Parameters
//   WIDTH    : counter width in bits (2..32)
//   MAX_VAL  : top of the count range (1..2**WIDTH-1); count stays in 0..MAX_VAL
//   SATURATE : 0 = wrap at the range ends, 1 = hold at the range ends
//   PRESCALE : enabled cycles per count step (1..256)
//
// Ports
//   clk      in   sole clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   en       in   count enable, advances the prescaler
//   clr      in   synchronous clear of count and prescaler (highest priority)
//   load     in   synchronous parallel load (value clamped to MAX_VAL)
//   load_val in   value written on load
//   up_dn    in   step direction, 1 = up, 0 = down
//   ovf_clr  in   synchronous clear of the sticky ovf flag
//   count    out  registered counter value
//   tc       out  registered one-cycle pulse following a range-end event
//   ovf      out  registered sticky range-end flag
// ---------------------------------------------------------------------------
module binary_counter_param #(
    parameter int unsigned       WIDTH    = 8,
    parameter logic [WIDTH-1:0]  MAX_VAL  = {WIDTH{1'b1}},
    parameter int unsigned       SATURATE = 0,
    parameter int unsigned       PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up_dn,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    // Prescaler needs at least one bit even when PRESCALE == 1; it then stays
    // at 0 permanently, which is also its terminal value, so every enabled
    // edge is a step.
    localparam int unsigned    PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PRE_TOP  = PW'(PRESCALE - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        count_d = count_q;
        presc_d = presc_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q & ~ovf_clr;

        if (clr) begin
            count_d = '0;
            presc_d = '0;
        end else if (load) begin
            count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
            presc_d = '0;
        end else if (en) begin
            if (presc_q == PRE_TOP) begin
                presc_d = '0;
                if (up_dn) begin
                    if (count_q == MAX_VAL) begin
                        count_d = (SATURATE != 0) ? MAX_VAL : '0;
                        tc_d    = 1'b1;
                        ovf_d   = 1'b1;  // set wins over a coincident ovf_clr
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end else begin
                    if (count_q == '0) begin
                        count_d = (SATURATE != 0) ? '0 : MAX_VAL;
                        tc_d    = 1'b1;
                        ovf_d   = 1'b1;
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            presc_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            presc_q <= presc_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_binary_counter_param.sv
// ---------------------------------------------------------------------------
// tb_binary_counter_param
//
// Three counter instances (WIDTH=4, MAX_VAL=9) share one stimulus bus:
//   u_wrap : SATURATE=0, PRESCALE=1
//   u_sat  : SATURATE=1, PRESCALE=1
//   u_pre  : SATURATE=0, PRESCALE=3
// A vector table exercises u_wrap; hand sequences cover saturation,
// prescaling and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_binary_counter_param;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic       load;
    logic [3:0] load_val;
    logic       up_dn;
    logic       ovf_clr;

    logic [3:0] cnt_a, cnt_b, cnt_c;
    logic       tc_a, tc_b, tc_c;
    logic       ovf_a, ovf_b, ovf_c;

    int n_cmp = 0;
    int n_err = 0;

    binary_counter_param #(
        .WIDTH(4), .MAX_VAL(4'd9), .SATURATE(0), .PRESCALE(1)
    ) u_wrap (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load),
        .load_val(load_val), .up_dn(up_dn), .ovf_clr(ovf_clr),
        .count(cnt_a), .tc(tc_a), .ovf(ovf_a)
    );

    binary_counter_param #(
        .WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1), .PRESCALE(1)
    ) u_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load),
        .load_val(load_val), .up_dn(up_dn), .ovf_clr(ovf_clr),
        .count(cnt_b), .tc(tc_b), .ovf(ovf_b)
    );

    binary_counter_param #(
        .WIDTH(4), .MAX_VAL(4'd9), .SATURATE(0), .PRESCALE(3)
    ) u_pre (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load),
        .load_val(load_val), .up_dn(up_dn), .ovf_clr(ovf_clr),
        .count(cnt_c), .tc(tc_c), .ovf(ovf_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       clr;
        logic       load;
        logic [3:0] load_val;
        logic       en;
        logic       up_dn;
        logic       ovf_clr;
        logic [3:0] exp_count;
        logic       exp_tc;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic c, input logic l, input logic [3:0] lv,
                                input logic e, input logic u, input logic oc,
                                input logic [3:0] xc, input logic xt, input logic xo);
        vec_t v;
        v.clr = c; v.load = l; v.load_val = lv; v.en = e; v.up_dn = u; v.ovf_clr = oc;
        v.exp_count = xc; v.exp_tc = xt; v.exp_ovf = xo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive inputs, take one rising edge, return 1 time unit after it.
    task automatic apply(input logic c, input logic l, input logic [3:0] lv,
                         input logic e, input logic u, input logic oc);
        clr = c; load = l; load_val = lv; en = e; up_dn = u; ovf_clr = oc;
        @(posedge clk);
        #1;
    endtask

    // Called 1 unit after an edge: assert reset between edges.
    task automatic reset_assert();
        #2 rst_n = 1'b0;
        #1;
    endtask

    task automatic reset_release();
        #2 rst_n = 1'b1;
    endtask

    logic [3:0] exp_seq[6];
    logic       exp_tcs[4];

    initial begin
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0;
        up_dn = 1'b1; ovf_clr = 1'b0;

        // Vector table for the wrapping instance.
        for (int i = 1; i <= 9; i++) vecs.push_back(mk(0, 0, 0, 1, 1, 0, 4'(i), 0, 0));
        vecs.push_back(mk(0, 0, 0,  1, 1, 0, 0, 1, 1));  // 9 -> 0 wrap
        vecs.push_back(mk(0, 0, 0,  1, 1, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0,  1, 1, 0, 2, 0, 1));
        vecs.push_back(mk(0, 0, 0,  1, 0, 0, 1, 0, 1));  // direction change
        vecs.push_back(mk(0, 0, 0,  0, 0, 0, 1, 0, 1));  // en=0 freezes
        vecs.push_back(mk(0, 0, 0,  1, 0, 1, 0, 0, 0));  // ovf_clr on normal step
        vecs.push_back(mk(0, 0, 0,  1, 0, 1, 9, 1, 1));  // ovf_clr vs event: set wins
        vecs.push_back(mk(0, 1, 5,  1, 0, 0, 5, 0, 1));  // load ignores en
        vecs.push_back(mk(1, 1, 5,  1, 1, 0, 0, 0, 1));  // clr beats load
        vecs.push_back(mk(0, 1, 15, 0, 1, 0, 9, 0, 1));  // load clamps to MAX_VAL
        vecs.push_back(mk(0, 0, 0,  0, 1, 1, 9, 0, 0));  // ovf_clr alone
        vecs.push_back(mk(0, 0, 0,  1, 1, 0, 0, 1, 1));  // wrap up
        vecs.push_back(mk(0, 0, 0,  1, 0, 0, 9, 1, 1));  // wrap down from 0
        vecs.push_back(mk(1, 0, 0,  1, 1, 0, 0, 0, 1));  // clr keeps ovf

        // Power-on reset.
        @(posedge clk);
        #1;
        chk("reset.count_a", 32'(cnt_a), 0);
        chk("reset.tc_a",    32'(tc_a),  0);
        chk("reset.ovf_a",   32'(ovf_a), 0);
        chk("reset.count_c", 32'(cnt_c), 0);
        reset_release();

        foreach (vecs[i]) begin
            apply(vecs[i].clr, vecs[i].load, vecs[i].load_val,
                  vecs[i].en, vecs[i].up_dn, vecs[i].ovf_clr);
            chk($sformatf("wrap[%0d].count", i), 32'(cnt_a), 32'(vecs[i].exp_count));
            chk($sformatf("wrap[%0d].tc", i),    32'(tc_a),  32'(vecs[i].exp_tc));
            chk($sformatf("wrap[%0d].ovf", i),   32'(ovf_a), 32'(vecs[i].exp_ovf));
        end

        // Saturating down: load 2, then four down steps.
        reset_assert();
        reset_release();
        apply(0, 1, 2, 0, 0, 0);
        chk("sat.load", 32'(cnt_b), 2);
        chk("sat.ovf0", 32'(ovf_b), 0);
        exp_seq = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        exp_tcs = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            apply(0, 0, 0, 1, 0, 0);
            chk($sformatf("sat_dn[%0d].count", i), 32'(cnt_b), 32'(exp_seq[i]));
            chk($sformatf("sat_dn[%0d].tc", i),    32'(tc_b),  32'(exp_tcs[i]));
            chk($sformatf("sat_dn[%0d].ovf", i),   32'(ovf_b), (i >= 2) ? 1 : 0);
        end
        // Reset during a tc pulse clears everything without a clock edge.
        reset_assert();
        chk("sat.rst.tc",    32'(tc_b),  0);
        chk("sat.rst.count", 32'(cnt_b), 0);
        chk("sat.rst.ovf",   32'(ovf_b), 0);
        reset_release();
        // Saturating up: held at MAX_VAL, each step pulses tc.
        apply(0, 1, 9, 0, 1, 0);
        for (int i = 0; i < 2; i++) begin
            apply(0, 0, 0, 1, 1, 0);
            chk($sformatf("sat_up[%0d].count", i), 32'(cnt_b), 9);
            chk($sformatf("sat_up[%0d].tc", i),    32'(tc_b),  1);
        end
        chk("sat_up.ovf", 32'(ovf_b), 1);

        // Prescale by 3.
        reset_assert();
        reset_release();
        exp_seq = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2};
        for (int i = 0; i < 6; i++) begin
            apply(0, 0, 0, 1, 1, 0);
            chk($sformatf("pre[%0d].count", i), 32'(cnt_c), 32'(exp_seq[i]));
            chk($sformatf("pre[%0d].tc", i),    32'(tc_c),  0);
        end
        apply(0, 0, 0, 1, 1, 0); chk("pre.gap0", 32'(cnt_c), 2);
        apply(0, 0, 0, 0, 0, 0); chk("pre.gap1", 32'(cnt_c), 2);
        apply(0, 0, 0, 0, 0, 0); chk("pre.gap2", 32'(cnt_c), 2);
        apply(0, 0, 0, 1, 1, 0); chk("pre.gap3", 32'(cnt_c), 2);
        apply(0, 0, 0, 1, 1, 0); chk("pre.gap4", 32'(cnt_c), 3);
        apply(0, 0, 0, 1, 1, 0); chk("pre.mid",  32'(cnt_c), 3);
        // Reset mid-prescale: phase discarded, first step needs 3 edges.
        reset_assert();
        chk("pre.rst.count", 32'(cnt_c), 0);
        reset_release();
        exp_seq = '{4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0};
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, 1, 1, 0);
            chk($sformatf("pre_rel[%0d].count", i), 32'(cnt_c), 32'(exp_seq[i]));
        end

        // Async reset with count=7, ovf=1 on the wrapping instance.
        apply(0, 1, 9, 0, 1, 0);
        apply(0, 0, 0, 1, 1, 0);
        apply(0, 1, 7, 0, 1, 0);
        chk("arst.pre.count", 32'(cnt_a), 7);
        chk("arst.pre.ovf",   32'(ovf_a), 1);
        reset_assert();
        chk("arst.count", 32'(cnt_a), 0);
        chk("arst.ovf",   32'(ovf_a), 0);
        chk("arst.tc",    32'(tc_a),  0);
        reset_release();
        apply(0, 0, 0, 1, 1, 0);
        chk("arst.first_step", 32'(cnt_a), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/binary_counter_param.md
BINARY_COUNTER_PARAM -- requirements
Module: binary_counter_param

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits, legal range 2..32.
REQ-002 Parameter MAX_VAL, default 2**WIDTH-1: top of count range, legal range 1..2**WIDTH-1.
REQ-003 Parameter SATURATE, default 0: 0 means wrap at range ends, 1 means hold at range ends.
REQ-004 Parameter PRESCALE, default 1: enabled cycles per count step, legal range 1..256.
REQ-005 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-006 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 Port en, input, 1: count enable; qualifies prescaler advance.
REQ-008 Port clr, input, 1: synchronous clear of count and prescaler.
REQ-009 Port load, input, 1: synchronous parallel load.
REQ-010 Port load_val, input, WIDTH: value written on load.
REQ-011 Port up_dn, input, 1: step direction, 1 means up, 0 means down.
REQ-012 Port ovf_clr, input, 1: synchronous clear of the sticky ovf flag.
REQ-013 Port count, output, WIDTH: registered counter value.
REQ-014 Port tc, output, 1: registered one-cycle terminal-count pulse.
REQ-015 Port ovf, output, 1: registered sticky flag for a range-end event.

Function
REQ-016 Per-edge priority SHALL be clr, then load, then step; only the highest-priority active operation takes effect.
REQ-017 clr SHALL set count to 0 and prescaler to 0 on the next edge; tc is 0 that cycle; ovf is unaffected.
REQ-018 load SHALL set count to min(load_val, MAX_VAL) and prescaler to 0; tc is 0 that cycle; en is ignored.
REQ-019 Prescaler SHALL be an internal counter 0..PRESCALE-1 that advances only on edges with en=1 and no clr/load.
REQ-020 A step SHALL occur on an edge where en=1, there is no clr/load, and the prescaler equals PRESCALE-1; the prescaler then returns to 0.
REQ-021 With PRESCALE=1, every enabled edge SHALL be a step, with no prescaler latency.
REQ-022 A step with up_dn=1 and count<MAX_VAL SHALL give count+1; a step with up_dn=0 and count>0 SHALL give count-1.
REQ-023 Range-end event, up: a step with up_dn=1 while count==MAX_VAL gives next count 0 if SATURATE=0, else MAX_VAL.
REQ-024 Range-end event, down: a step with up_dn=0 while count==0 gives next count MAX_VAL if SATURATE=0, else 0.
REQ-025 tc SHALL be 1 in exactly the cycle following a range-end event edge, coincident with the new count value, and 0 otherwise.
REQ-026 Repeated steps held at a saturated end SHALL each produce a tc pulse.
REQ-027 ovf SHALL be set on any range-end event edge and held until ovf_clr or reset.
REQ-028 If ovf_clr and a range-end event occur on the same edge, ovf SHALL be 1 (set wins).
REQ-029 up_dn MAY change on any cycle and takes effect on the next step; the prescaler phase is not disturbed.
REQ-030 en=0 SHALL freeze count and prescaler; tc is 0.
REQ-031 All arithmetic SHALL be unsigned and modulo-free; count never leaves 0..MAX_VAL.

Reset
REQ-032 rst_n=0 SHALL immediately, without waiting for clk, force count=0, prescaler=0, tc=0 and ovf=0.
REQ-033 Reset asserted mid-prescale or mid-pulse SHALL discard all in-flight state; there is no step on release.
REQ-034 After rst_n rises, the first step SHALL need PRESCALE enabled edges.

Verification (WIDTH=4, MAX_VAL=9 unless stated)
REQ-035 Wrap up, PRESCALE=1, SATURATE=0: release reset, hold en=1 and up_dn=1 for 12 edges -> count runs 1..9,0,1,2; tc is high only when count=0; ovf=1 from then on.
REQ-036 Saturate down, SATURATE=1: load 2, set up_dn=0, then 4 enabled edges -> count 1,0,0,0; tc high on the last two cycles; ovf=1.
REQ-037 Prescale, PRESCALE=3: with en=1 and up_dn=1, count advances every 3rd edge (0,0,1,1,1,2); dropping en for 2 cycles mid-phase delays the next step by 2.
REQ-038 Priority: clr=1, load=1 with load_val=5 and en=1 on one edge -> count=0; load alone with load_val=15 -> count=9 (clamped).
REQ-039 ovf race: ovf=1, ovf_clr on a normal step -> ovf=0; ovf_clr coincident with a range-end event -> ovf stays 1.
REQ-040 Async reset: drive rst_n low between clock edges with count=7 and ovf=1 -> count=0 and ovf=0 before the next edge; after release, no step until PRESCALE enabled edges.
